// File: rtl/mining_ctrl_v2_if.sv
// BRAM and hash-core channels of the nonce-search controller.
// master = controller side, slave = memory / hash-core side.
interface mining_ctrl_v2_if #(
    parameter int unsigned CHUNK_W = 512,
    parameter int unsigned HASH_W  = 256,
    parameter int unsigned ADDR_W  = 16
) ();
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic               mem_re;
    logic [CHUNK_W-1:0] mem_wdata;
    logic [CHUNK_W-1:0] mem_rdata;
    logic [CHUNK_W-1:0] chunk;
    logic               chunk_valid;
    logic               chunk_last;
    logic               chunk_ready;
    logic               hash_valid;
    logic [HASH_W-1:0]  hash;

    modport master (
        output mem_addr, mem_we, mem_re, mem_wdata,
        output chunk, chunk_valid, chunk_last,
        input  mem_rdata, chunk_ready, hash_valid, hash
    );

    modport slave (
        input  mem_addr, mem_we, mem_re, mem_wdata,
        input  chunk, chunk_valid, chunk_last,
        output mem_rdata, chunk_ready, hash_valid, hash
    );
endinterface

// File: rtl/mining_ctrl_v2.sv
// Nonce-search controller: streams header chunks from BRAM to the hash core with
// the current nonce patched in, then checks each digest against the difficulty.
module mining_ctrl_v2 #(
    parameter int unsigned CHUNK_W = 512,
    parameter int unsigned HASH_W  = 256,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned NONCE_W = 32,
    parameter int unsigned DIFF_W  = 9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_load_we,
    input  logic [ADDR_W-1:0]  i_load_addr,
    input  logic [CHUNK_W-1:0] i_load_data,
    input  logic [ADDR_W-1:0]  i_num_chunks,
    input  logic [ADDR_W-1:0]  i_nonce_chunk,
    input  logic [8:0]         i_nonce_msb,
    input  logic [NONCE_W-1:0] i_nonce_start,
    input  logic [NONCE_W-1:0] i_nonce_limit,
    input  logic [DIFF_W-1:0]  i_difficulty,
    input  logic               i_start,
    input  logic               i_abort,
    mining_ctrl_v2_if.master   bus,
    output logic               o_busy,
    output logic               o_found,
    output logic               o_exhausted,
    output logic [NONCE_W-1:0] o_found_nonce,
    output logic [NONCE_W-1:0] o_attempts
);

    localparam int unsigned MSB_W = 9;
    localparam int unsigned SAT_W = $clog2(HASH_W + 1);
    localparam int unsigned PAD_W = CHUNK_W - NONCE_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_SEND,
        S_HASH,
        S_CHECK
    } state_t;

    state_t             r_state,       w_state_nxt;
    logic [ADDR_W-1:0]  r_idx,         w_idx_nxt;
    logic [NONCE_W-1:0] r_cur_nonce,   w_cur_nonce_nxt;
    logic [ADDR_W-1:0]  r_num_chunks,  w_num_chunks_nxt;
    logic [ADDR_W-1:0]  r_nonce_chunk, w_nonce_chunk_nxt;
    logic [MSB_W-1:0]   r_nonce_lsb,   w_nonce_lsb_nxt;
    logic [NONCE_W-1:0] r_nonce_limit, w_nonce_limit_nxt;
    logic [SAT_W-1:0]   r_difficulty,  w_difficulty_nxt;
    logic [CHUNK_W-1:0] r_chunk,       w_chunk_nxt;
    logic               r_chunk_last,  w_chunk_last_nxt;
    logic [HASH_W-1:0]  r_digest,      w_digest_nxt;
    logic               r_busy,        w_busy_nxt;
    logic               r_found,       w_found_nxt;
    logic               r_exhausted,   w_exhausted_nxt;
    logic [NONCE_W-1:0] r_found_nonce, w_found_nonce_nxt;
    logic [NONCE_W-1:0] r_attempts,    w_attempts_nxt;

    logic               w_load_pass;
    logic [MSB_W-1:0]   w_lsb_in;
    logic [SAT_W-1:0]   w_diff_sat;
    logic [CHUNK_W-1:0] w_patch_mask;
    logic [CHUNK_W-1:0] w_nonce_ext;
    logic [CHUNK_W-1:0] w_patched;
    logic [HASH_W-1:0]  w_zero_mask;
    logic               w_pass;

    // Nonce field position is stored as its LSB; MSBs below NONCE_W-1 clamp to bit 0.
    assign w_lsb_in = (i_nonce_msb < MSB_W'(NONCE_W - 1)) ? '0
                    : i_nonce_msb - MSB_W'(NONCE_W - 1);
    assign w_diff_sat = (32'(i_difficulty) > HASH_W) ? SAT_W'(HASH_W) : SAT_W'(i_difficulty);

    assign w_patch_mask = {{PAD_W{1'b0}}, {NONCE_W{1'b1}}} << r_nonce_lsb;
    assign w_nonce_ext  = {{PAD_W{1'b0}}, r_cur_nonce} << r_nonce_lsb;
    assign w_patched    = (bus.mem_rdata & ~w_patch_mask) | w_nonce_ext;

    // Leading-zero test: a shift of HASH_W yields an all-ones mask, difficulty 0 an empty one.
    assign w_zero_mask = ~({HASH_W{1'b1}} >> r_difficulty);
    assign w_pass      = ~|(r_digest & w_zero_mask);

    // Host writes go straight to the BRAM port while idle and out of reset.
    assign w_load_pass   = reset && (r_state == S_IDLE) && i_load_we;
    assign bus.mem_we    = w_load_pass;
    assign bus.mem_wdata = w_load_pass ? i_load_data : '0;
    assign bus.mem_re    = (r_state == S_RD);
    assign bus.mem_addr  = w_load_pass ? i_load_addr
                         : ((r_state == S_RD) ? r_idx : '0);

    assign bus.chunk       = r_chunk;
    assign bus.chunk_valid = (r_state == S_SEND);
    assign bus.chunk_last  = r_chunk_last;

    assign o_busy        = r_busy;
    assign o_found       = r_found;
    assign o_exhausted   = r_exhausted;
    assign o_found_nonce = r_found_nonce;
    assign o_attempts    = r_attempts;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_cur_nonce   <= '0;
            r_num_chunks  <= '0;
            r_nonce_chunk <= '0;
            r_nonce_lsb   <= '0;
            r_nonce_limit <= '0;
            r_difficulty  <= '0;
            r_chunk       <= '0;
            r_chunk_last  <= 1'b0;
            r_digest      <= '0;
            r_busy        <= 1'b0;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_found_nonce <= '0;
            r_attempts    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_cur_nonce   <= w_cur_nonce_nxt;
            r_num_chunks  <= w_num_chunks_nxt;
            r_nonce_chunk <= w_nonce_chunk_nxt;
            r_nonce_lsb   <= w_nonce_lsb_nxt;
            r_nonce_limit <= w_nonce_limit_nxt;
            r_difficulty  <= w_difficulty_nxt;
            r_chunk       <= w_chunk_nxt;
            r_chunk_last  <= w_chunk_last_nxt;
            r_digest      <= w_digest_nxt;
            r_busy        <= w_busy_nxt;
            r_found       <= w_found_nxt;
            r_exhausted   <= w_exhausted_nxt;
            r_found_nonce <= w_found_nonce_nxt;
            r_attempts    <= w_attempts_nxt;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_cur_nonce_nxt   = r_cur_nonce;
        w_num_chunks_nxt  = r_num_chunks;
        w_nonce_chunk_nxt = r_nonce_chunk;
        w_nonce_lsb_nxt   = r_nonce_lsb;
        w_nonce_limit_nxt = r_nonce_limit;
        w_difficulty_nxt  = r_difficulty;
        w_chunk_nxt       = r_chunk;
        w_chunk_last_nxt  = r_chunk_last;
        w_digest_nxt      = r_digest;
        w_busy_nxt        = r_busy;
        w_found_nxt       = r_found;
        w_exhausted_nxt   = r_exhausted;
        w_found_nonce_nxt = r_found_nonce;
        w_attempts_nxt    = r_attempts;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_cur_nonce_nxt   = i_nonce_start;
                    w_num_chunks_nxt  = i_num_chunks;
                    w_nonce_chunk_nxt = i_nonce_chunk;
                    w_nonce_lsb_nxt   = w_lsb_in;
                    w_nonce_limit_nxt = i_nonce_limit;
                    w_difficulty_nxt  = w_diff_sat;
                    w_found_nxt       = 1'b0;
                    w_exhausted_nxt   = 1'b0;
                    w_attempts_nxt    = '0;
                    w_busy_nxt        = 1'b1;
                    w_idx_nxt         = '0;
                    w_state_nxt       = S_RD;
                end
            end
            S_RD: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_chunk_nxt      = (r_idx == r_nonce_chunk) ? w_patched : bus.mem_rdata;
                w_chunk_last_nxt = (r_idx == r_num_chunks);
                w_state_nxt      = S_SEND;
            end
            S_SEND: begin
                if (bus.chunk_ready) begin
                    if (r_chunk_last) begin
                        w_state_nxt = S_HASH;
                    end else begin
                        w_idx_nxt   = r_idx + ADDR_W'(1);
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_HASH: begin
                if (bus.hash_valid) begin
                    w_attempts_nxt = r_attempts + NONCE_W'(1);
                    w_digest_nxt   = bus.hash;
                    w_state_nxt    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_pass) begin
                    w_found_nxt       = 1'b1;
                    w_found_nonce_nxt = r_cur_nonce;
                    w_busy_nxt        = 1'b0;
                    w_state_nxt       = S_IDLE;
                end else if (r_cur_nonce == r_nonce_limit) begin
                    w_exhausted_nxt = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_cur_nonce_nxt = r_cur_nonce + NONCE_W'(1);
                    w_idx_nxt       = '0;
                    w_state_nxt     = S_RD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // Abort wins over any progress made in the same cycle.
        if (i_abort && (r_state != S_IDLE)) begin
            w_state_nxt       = S_IDLE;
            w_busy_nxt        = 1'b0;
            w_found_nxt       = r_found;
            w_exhausted_nxt   = r_exhausted;
            w_found_nonce_nxt = r_found_nonce;
            w_attempts_nxt    = r_attempts;
        end
    end

endmodule

// File: tb/tb_mining_ctrl_v2.sv
// Self-checking bench for mining_ctrl_v2: BRAM and hash-core models, chunk scoreboard,
// a table of search cases and hand-written stall / abort / reset sequences.
module tb_mining_ctrl_v2;

    localparam int unsigned CHUNK_W = 512;
    localparam int unsigned HASH_W  = 256;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned NONCE_W = 32;
    localparam int unsigned DIFF_W  = 9;
    localparam int HLAT    = 2;
    localparam int TIMEOUT = 4000;
    localparam logic [HASH_W-1:0] DIG_PASS = {10'b0, {246{1'b1}}};
    localparam logic [HASH_W-1:0] DIG_FAIL = {HASH_W{1'b1}};

    typedef struct packed {
        logic [31:0] nstart;
        logic [31:0] nlimit;
        logic [8:0]  diff;
        logic [8:0]  msb;
        logic [15:0] nch;
        logic [15:0] nci;
        logic [31:0] pass;
        logic        efound;
        logic        eexh;
        logic [31:0] efn;
        logic [31:0] eatt;
    } vec_t;

    typedef struct packed {
        logic [CHUNK_W-1:0] data;
        logic               last;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               load_we;
    logic [ADDR_W-1:0]  load_addr;
    logic [CHUNK_W-1:0] load_data;
    logic [ADDR_W-1:0]  num_chunks;
    logic [ADDR_W-1:0]  nonce_chunk;
    logic [8:0]         nonce_msb;
    logic [NONCE_W-1:0] nonce_start;
    logic [NONCE_W-1:0] nonce_limit;
    logic [DIFF_W-1:0]  difficulty;
    logic               start;
    logic               abort;
    logic               busy;
    logic               found;
    logic               exhausted;
    logic [NONCE_W-1:0] found_nonce;
    logic [NONCE_W-1:0] attempts;

    logic               ready;
    logic               hash_en;
    logic               m_hv;
    logic [HASH_W-1:0]  m_hash;
    logic               f_hv;
    logic [HASH_W-1:0]  f_hash;
    logic [CHUNK_W-1:0] rdata_q;
    logic [CHUNK_W-1:0] mem_arr [0:3];
    logic [CHUNK_W-1:0] host [0:1];
    logic [31:0]        pass_nonce;
    logic [31:0]        cap_nonce;
    logic [8:0]         cfg_msb;
    logic [15:0]        cfg_nci;
    int                 hcnt;
    int                 ccount;
    int                 hs_cnt;
    int                 hs_last_cnt;
    int                 errors;
    int                 checks;
    exp_t               sb_q[$];
    exp_t               mon_e;
    vec_t               vecs [7];

    always #5 clock = ~clock;

    mining_ctrl_v2_if #(.CHUNK_W(CHUNK_W), .HASH_W(HASH_W), .ADDR_W(ADDR_W)) bus ();

    mining_ctrl_v2 #(
        .CHUNK_W(CHUNK_W), .HASH_W(HASH_W), .ADDR_W(ADDR_W),
        .NONCE_W(NONCE_W), .DIFF_W(DIFF_W)
    ) dut (
        .clock(clock), .reset(reset),
        .i_load_we(load_we), .i_load_addr(load_addr), .i_load_data(load_data),
        .i_num_chunks(num_chunks), .i_nonce_chunk(nonce_chunk), .i_nonce_msb(nonce_msb),
        .i_nonce_start(nonce_start), .i_nonce_limit(nonce_limit), .i_difficulty(difficulty),
        .i_start(start), .i_abort(abort), .bus(bus),
        .o_busy(busy), .o_found(found), .o_exhausted(exhausted),
        .o_found_nonce(found_nonce), .o_attempts(attempts)
    );

    assign bus.chunk_ready = ready;
    assign bus.hash_valid  = m_hv | f_hv;
    assign bus.hash        = f_hv ? f_hash : m_hash;
    assign bus.mem_rdata   = rdata_q;

    function automatic logic [CHUNK_W-1:0] patch(input logic [CHUNK_W-1:0] d,
                                                  input logic [8:0] msb, input logic [31:0] n);
        int lsb = (msb < 9'd31) ? 0 : int'(msb) - 31;
        for (int i = 0; i < 32; i++) d[lsb + i] = n[i];
        return d;
    endfunction

    function automatic logic [31:0] extract(input logic [CHUNK_W-1:0] d, input logic [8:0] msb);
        logic [31:0] r;
        int lsb = (msb < 9'd31) ? 0 : int'(msb) - 31;
        for (int i = 0; i < 32; i++) r[i] = d[lsb + i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic chkw(input string nm, input logic [CHUNK_W-1:0] act, input logic [CHUNK_W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // BRAM model: synchronous write, one-cycle read latency.
    always @(posedge clock) begin
        if (bus.mem_we) mem_arr[bus.mem_addr[1:0]] <= bus.mem_wdata;
        if (bus.mem_re) rdata_q <= mem_arr[bus.mem_addr[1:0]];
    end

    // Hash-core model plus scoreboard; a handshake seen here is accepted at the next posedge.
    always @(negedge clock) begin
        m_hv <= 1'b0;
        if (hcnt == 1 && hash_en) begin
            m_hv   <= 1'b1;
            m_hash <= (cap_nonce == pass_nonce) ? DIG_PASS : DIG_FAIL;
        end
        if (hcnt != 0) hcnt <= hcnt - 1;
        if (!busy) ccount <= 0;
        if (reset && bus.chunk_valid && bus.chunk_ready) begin
            hs_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got chunk %0h expected none", bus.chunk[63:0]);
            end else begin
                mon_e = sb_q.pop_front();
                chkw("sb_chunk", bus.chunk, mon_e.data);
                chk("sb_last", 64'(bus.chunk_last), 64'(mon_e.last));
            end
            if (ccount == int'(cfg_nci)) cap_nonce <= extract(bus.chunk, cfg_msb);
            if (bus.chunk_last) begin
                hcnt <= HLAT;
                ccount <= 0;
                hs_last_cnt++;
            end else begin
                ccount <= ccount + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setup(input vec_t v);
        nonce_start = v.nstart;
        nonce_limit = v.nlimit;
        difficulty  = v.diff;
        nonce_msb   = v.msb;
        num_chunks  = v.nch;
        nonce_chunk = v.nci;
        pass_nonce  = v.pass;
        cfg_msb     = v.msb;
        cfg_nci     = v.nci;
    endtask

    task automatic push_attempts(input vec_t v, input int n_att);
        exp_t e;
        logic [31:0] n;
        for (int a = 0; a < n_att; a++) begin
            n = v.nstart + 32'(a);
            for (int c = 0; c <= int'(v.nch); c++) begin
                e.data = host[c];
                if (c == int'(v.nci)) e.data = patch(host[c], v.msb, n);
                e.last = (c == int'(v.nch));
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < TIMEOUT) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, 64'(busy), 64'(0));
    endtask

    task automatic run_case(input string nm, input vec_t v);
        setup(v);
        push_attempts(v, int'(v.eatt));
        pulse_start();
        chk({nm, "_busy"}, 64'(busy), 64'(1));
        wait_idle(nm);
        chk({nm, "_found"}, 64'(found), 64'(v.efound));
        chk({nm, "_exh"}, 64'(exhausted), 64'(v.eexh));
        chk({nm, "_attempts"}, 64'(attempts), 64'(v.eatt));
        if (v.efound) chk({nm, "_nonce"}, 64'(found_nonce), 64'(v.efn));
        chk({nm, "_sb_left"}, 64'(sb_q.size()), 64'(0));
        sb_q.delete();
    endtask

    task automatic load_chunk(input logic [ADDR_W-1:0] a, input logic [CHUNK_W-1:0] d, input bit check);
        load_we = 1'b1;
        load_addr = a;
        load_data = d;
        #1;
        if (check) begin
            chk("load_we_pass", 64'(bus.mem_we), 64'(1));
            chk("load_addr_pass", 64'(bus.mem_addr), 64'(a));
            chkw("load_data_pass", bus.mem_wdata, d);
        end
        tick();
        load_we = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic [CHUNK_W-1:0] held;
        int n;
        int base;

        errors = 0; checks = 0; hcnt = 0; ccount = 0; hs_cnt = 0; hs_last_cnt = 0;
        load_we = 0; load_addr = '0; load_data = '0; num_chunks = '0; nonce_chunk = '0;
        nonce_msb = '0; nonce_start = '0; nonce_limit = '0; difficulty = '0;
        start = 0; abort = 0; ready = 1; hash_en = 1; f_hv = 0; f_hash = '0;
        m_hv = 0; m_hash = '0; rdata_q = '0; pass_nonce = '0; cap_nonce = '0;
        cfg_msb = '0; cfg_nci = '0;
        for (int i = 0; i < 16; i++) begin
            host[0][i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
            host[1][i*32 +: 32] = 32'hBEEF_0000 + 32'(i);
        end

        //        nstart        nlimit        diff    msb     nch     nci     pass          fnd   exh   fnonce       att
        vecs[0] = '{32'h5,        32'h5,        9'd0,   9'd127, 16'd1, 16'd1, 32'h9999,     1'b1, 1'b0, 32'h5,   32'd1};
        vecs[1] = '{32'h10,       32'h20,       9'd10,  9'd127, 16'd1, 16'd1, 32'h12,       1'b1, 1'b0, 32'h12,  32'd3};
        vecs[2] = '{32'hFFFFFFFE, 32'h1,        9'd10,  9'd127, 16'd1, 16'd1, 32'h9999,     1'b0, 1'b1, 32'h0,   32'd4};
        vecs[3] = '{32'h7,        32'h9,        9'd11,  9'd127, 16'd1, 16'd1, 32'h8,        1'b0, 1'b1, 32'h0,   32'd3};
        vecs[4] = '{32'h40,       32'h40,       9'd10,  9'd5,   16'd0, 16'd0, 32'h40,       1'b1, 1'b0, 32'h40,  32'd1};
        vecs[5] = '{32'h3,        32'h4,        9'd300, 9'd511, 16'd1, 16'd0, 32'h3,        1'b0, 1'b1, 32'h0,   32'd2};
        vecs[6] = '{32'h100,      32'h105,      9'd9,   9'd300, 16'd1, 16'd1, 32'h102,      1'b1, 1'b0, 32'h102, 32'd3};

        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_found", 64'(found), 64'(0));
        chk("rst_exh", 64'(exhausted), 64'(0));
        chk("rst_attempts", 64'(attempts), 64'(0));
        chk("rst_valid", 64'(bus.chunk_valid), 64'(0));
        reset = 1'b1;
        tick();

        load_chunk(16'd0, host[0], 1'b1);
        load_chunk(16'd1, host[1], 1'b0);

        for (int i = 0; i < 7; i++) run_case($sformatf("vec%0d", i), vecs[i]);

        // chunk_ready held low in SEND: chunk must hold and no handshake may happen
        v = vecs[0];
        v.nstart = 32'h55; v.nlimit = 32'h55; v.efn = 32'h55;
        setup(v);
        push_attempts(v, 1);
        ready = 1'b0;
        base = hs_cnt;
        pulse_start();
        n = 0;
        while (!bus.chunk_valid && n < 100) begin tick(); n++; end
        chk("stall_reach_send", 64'(bus.chunk_valid), 64'(1));
        held = bus.chunk;
        chkw("stall_chunk0", held, host[0]);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_valid", 64'(bus.chunk_valid), 64'(1));
            chkw("stall_hold", bus.chunk, held);
            chk("stall_last", 64'(bus.chunk_last), 64'(0));
        end
        chk("stall_no_accept", 64'(hs_cnt - base), 64'(0));
        ready = 1'b1;
        wait_idle("stall");
        chk("stall_hs_total", 64'(hs_cnt - base), 64'(2));
        chk("stall_found", 64'(found), 64'(1));
        chk("stall_nonce", 64'(found_nonce), 64'(32'h55));
        chk("stall_sb_left", 64'(sb_q.size()), 64'(0));
        sb_q.delete();

        // abort while waiting for the digest; a late hash pulse must be ignored
        v = vecs[1];
        v.nstart = 32'h77; v.nlimit = 32'h80; v.pass = 32'h9999;
        setup(v);
        push_attempts(v, 1);
        hash_en = 1'b0;
        base = hs_last_cnt;
        pulse_start();
        n = 0;
        while (hs_last_cnt == base && n < 100) begin tick(); n++; end
        chk("abort_reach_hash", 64'(hs_last_cnt - base), 64'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_found", 64'(found), 64'(0));
        chk("abort_exh", 64'(exhausted), 64'(0));
        chk("abort_valid", 64'(bus.chunk_valid), 64'(0));
        f_hash = '0;
        f_hv = 1'b1;
        tick();
        f_hv = 1'b0;
        tick();
        chk("late_hash_found", 64'(found), 64'(0));
        chk("late_hash_attempts", 64'(attempts), 64'(0));
        chk("late_hash_busy", 64'(busy), 64'(0));
        chk("abort_sb_left", 64'(sb_q.size()), 64'(0));
        sb_q.delete();
        hash_en = 1'b1;
        v = vecs[0];
        v.nstart = 32'h77; v.nlimit = 32'h77; v.efn = 32'h77;
        run_case("restart", v);

        // host write while busy, then synchronous reset in SEND
        v = vecs[1];
        v.nstart = 32'h200; v.nlimit = 32'h210; v.pass = 32'h9999;
        setup(v);
        ready = 1'b0;
        pulse_start();
        n = 0;
        while (!bus.chunk_valid && n < 100) begin tick(); n++; end
        chk("rst_reach_send", 64'(bus.chunk_valid), 64'(1));
        load_we = 1'b1; load_addr = 16'd0; load_data = ~host[0];
        #1;
        chk("busy_load_we", 64'(bus.mem_we), 64'(0));
        tick();
        load_we = 1'b0;
        reset = 1'b0;
        tick();
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_found", 64'(found), 64'(0));
        chk("mrst_exh", 64'(exhausted), 64'(0));
        chk("mrst_fnonce", 64'(found_nonce), 64'(0));
        chk("mrst_attempts", 64'(attempts), 64'(0));
        chk("mrst_valid", 64'(bus.chunk_valid), 64'(0));
        chk("mrst_last", 64'(bus.chunk_last), 64'(0));
        chkw("mrst_chunk", bus.chunk, '0);
        chk("mrst_mem_re", 64'(bus.mem_re), 64'(0));
        chk("mrst_mem_we", 64'(bus.mem_we), 64'(0));
        chk("mrst_mem_addr", 64'(bus.mem_addr), 64'(0));
        reset = 1'b1;
        ready = 1'b1;
        tick();
        sb_q.delete();
        v = vecs[0];
        v.nstart = 32'h33; v.nlimit = 32'h33; v.efn = 32'h33;
        run_case("post_reset", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mining_ctrl_v2.md
Name: mining_ctrl_v2

Overview:
- Parametrised nonce-search controller for the mining datapath. It sits between the block-header BRAM and the SHA-256 chunk engine.
- Per attempt: streams header chunks from BRAM to the hash core, patching the current nonce into the header on the fly, then checks the digest against a runtime difficulty.
- Supports a bounded nonce range, an abort input, and a found/exhausted status.

Parameters:
CHUNK_W, 512, chunk width to hash core and BRAM data width
HASH_W, 256, digest width
ADDR_W, 16, BRAM address width
NONCE_W, 32, nonce width
DIFF_W, 9, difficulty field width (leading-zero bit count)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
load_we  in  1  host chunk write strobe (honoured only in IDLE)
load_addr  in  ADDR_W  host chunk write address
load_data  in  CHUNK_W  host chunk write data
num_chunks  in  ADDR_W  chunks per attempt, minus 1 (0 = one chunk)
nonce_chunk  in  ADDR_W  index of chunk holding the nonce
nonce_msb  in  9  bit position of nonce MSB inside that chunk
nonce_start  in  NONCE_W  first nonce tried
nonce_limit  in  NONCE_W  last nonce tried (inclusive)
difficulty  in  DIFF_W  required leading zero bits of digest
start  in  1  begin search (IDLE only)
abort  in  1  stop search, return to IDLE
mem_addr  out  ADDR_W  BRAM address
mem_we  out  1  BRAM write enable
mem_re  out  1  BRAM read enable
mem_wdata  out  CHUNK_W  BRAM write data
mem_rdata  in  CHUNK_W  BRAM read data, valid 1 cycle after mem_re
chunk  out  CHUNK_W  chunk to hash core
chunk_valid  out  1  chunk valid
chunk_last  out  1  final chunk of current attempt
chunk_ready  in  1  hash core accepts chunk
hash_valid  in  1  digest valid (1-cycle pulse)
hash  in  HASH_W  digest
busy  out  1  search in progress
found  out  1  winning nonce found (sticky until next start)
exhausted  out  1  range finished, no winner (sticky until next start)
found_nonce  out  NONCE_W  winning nonce
attempts  out  NONCE_W  attempts completed in current search

Behaviour:
- Reset (reset=0 at clock edge): state=IDLE; all outputs 0. Reset overrides every other input in the same cycle.
- IDLE:
  - load_we=1 drives mem_we=1, mem_addr=load_addr, mem_wdata=load_data in the same cycle (combinational pass-through, registered by BRAM). load_we outside IDLE is ignored.
  - start=1: latch nonce_start into cur_nonce. Latch num_chunks, nonce_chunk, nonce_msb, nonce_limit and difficulty (saturated to HASH_W). Clear found, exhausted and attempts. Set busy=1, idx=0, go to RD.
- RD: mem_re=1, mem_addr=idx; next WAIT.
- WAIT: capture mem_rdata into the chunk register. When idx==nonce_chunk, bits [nonce_msb -: NONCE_W] are replaced by cur_nonce; a nonce_msb below NONCE_W-1 is clamped to NONCE_W-1. Next SEND.
- SEND: chunk_valid=1, chunk_last=(idx==num_chunks). chunk and chunk_last hold stable until chunk_ready=1. On handshake:
  - if last, go to HASH;
  - else idx+1, go to RD.
- HASH: wait for hash_valid. Then attempts+1, go to CHECK with the digest registered.
- CHECK:
  - digest[HASH_W-1 -: difficulty] all zero (difficulty=0 always passes): found=1, found_nonce=cur_nonce, busy=0, go to IDLE.
  - else if cur_nonce==nonce_limit: exhausted=1, busy=0, go to IDLE.
  - else cur_nonce+1 (wraps modulo 2^NONCE_W; range nonce_start>nonce_limit searches through wrap), idx=0, go to RD.
- Abort: abort=1 in any non-IDLE state goes to IDLE next cycle. It sets busy=0 and chunk_valid=0, and leaves found/exhausted 0. Any hash_valid that arrives later in IDLE is ignored.
- start while busy is ignored. A hash_valid outside HASH is ignored.
- Latency per attempt with zero-wait hash core: 3 cycles per chunk, plus hash latency, plus 2 cycles (HASH capture and CHECK).
- Only one of found/exhausted is ever 1. Both stay stable until the next accepted start or reset.

Test Plan:
- Load 2 chunks, num_chunks=1, nonce_chunk=1, nonce_msb=127, nonce_start=5, difficulty=0, model returns any digest -> found=1, found_nonce=5, attempts=1. Chunk 1 bits [127:96]=5.
- difficulty=10, model digest top 10 bits zero only when nonce=0x12 (nonce_start=0x10, limit=0x20) -> found_nonce=0x12, attempts=3. Chunk sequence 0,1 repeated 3 times, chunk_last on idx 1 only.
- nonce_start=0xFFFFFFFE, limit=0x00000001, digest never passes -> 4 attempts with nonces FFFFFFFE, FFFFFFFF, 0, 1, then exhausted=1, found=0.
- chunk_ready held low 5 cycles in SEND -> chunk/chunk_last stable, no duplicate accept; one chunk per handshake.
- abort asserted during HASH, then hash_valid pulses -> busy=0 next cycle, found=exhausted=0, pulse ignored. A following start restarts from nonce_start.
- reset=0 mid-search in SEND -> next cycle all outputs 0, state IDLE. load_we during busy -> mem_we stays 0.
